// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the combinational ROM and
// registers {pc, pc+4, instr} for decode over a valid/ready handshake.
//
// Ports:
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   imem_addr         ROM byte address, always equal to the current pc
//   imem_data         ROM word for imem_addr, valid in the same cycle
//   redirect_valid/pc load a new fetch target and squash the held word
//   out_valid/ready   handshake towards decode
//   out_pc            address of out_instr
//   out_pc_plus4      out_pc + 4 (wraps)
//   out_instr         fetched instruction
//   fault, fault_pc   sticky stop on an illegal pc, and that pc
module fetch_unit #(
    parameter int unsigned           ADDR_WIDTH      = 32,
    parameter int unsigned           DATA_WIDTH      = 32,
    parameter int unsigned           MEM_DEPTH_BYTES = 1024,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [ADDR_WIDTH-1:0] out_pc_plus4,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic                  fault,
    output logic [ADDR_WIDTH-1:0] fault_pc
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_FAULT
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST_PC =
        ADDR_WIDTH'(MEM_DEPTH_BYTES - 4);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(4);

    // Wrapped addresses land far above LAST_PC, so they are illegal too.
    function automatic logic legal(input logic [ADDR_WIDTH-1:0] a);
        return (a[1:0] == 2'b00) && (a <= LAST_PC);
    endfunction

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic                    valid_q, valid_d;
    logic [ADDR_WIDTH-1:0]   opc_q, opc_d;
    logic [ADDR_WIDTH-1:0]   op4_q, op4_d;
    logic [DATA_WIDTH-1:0]   instr_q, instr_d;
    logic                    fault_q, fault_d;
    logic [ADDR_WIDTH-1:0]   fault_pc_q, fault_pc_d;
    logic [ADDR_WIDTH-1:0]   pc_next;
    logic                    advance;

    assign pc_next = pc_q + STEP;
    assign advance = !valid_q || out_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        opc_d      = opc_q;
        op4_d      = op4_q;
        instr_d    = instr_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        unique case (state_q)
            ST_BOOT: begin
                if (legal(pc_q)) begin
                    state_d = ST_RUN;
                end else begin
                    state_d    = ST_FAULT;
                    fault_d    = 1'b1;
                    fault_pc_d = pc_q;
                end
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    // A same-cycle handshake is simply dropped with the squash.
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                    if (!legal(redirect_pc)) begin
                        state_d    = ST_FAULT;
                        fault_d    = 1'b1;
                        fault_pc_d = redirect_pc;
                    end
                end else if (advance) begin
                    instr_d = imem_data;
                    opc_d   = pc_q;
                    op4_d   = pc_next;
                    valid_d = 1'b1;
                    if (legal(pc_next)) begin
                        pc_d = pc_next;
                    end else begin
                        state_d    = ST_FAULT;
                        fault_d    = 1'b1;
                        fault_pc_d = pc_next;
                    end
                end
            end
            ST_FAULT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                    if (legal(redirect_pc)) begin
                        state_d = ST_RUN;
                        fault_d = 1'b0;
                    end else begin
                        fault_pc_d = redirect_pc;
                    end
                end else if (valid_q && out_ready) begin
                    // The last captured word may still drain.
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            opc_q      <= '0;
            op4_q      <= '0;
            instr_q    <= '0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            opc_q      <= opc_d;
            op4_q      <= op4_d;
            instr_q    <= instr_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    assign imem_addr    = pc_q;
    assign out_valid    = valid_q;
    assign out_pc       = opc_q;
    assign out_pc_plus4 = op4_q;
    assign out_instr    = instr_q;
    assign fault        = fault_q;
    assign fault_pc     = fault_pc_q;

endmodule
